// File: rtl/trng_pkg.sv
// Shared types and sizing helpers for the TRNG bit collector.
package trng_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_COLLECT,
        ST_FAIL
    } state_t;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_RCT  = 2'b01;
    localparam logic [1:0] CAUSE_APT  = 2'b10;
    localparam logic [1:0] CAUSE_BOTH = 2'b11;

    // Bits needed to hold values 0..max_val inclusive.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/trng_health_test.sv
// Continuous repetition-count and adaptive-proportion tests on the sampled stream.
module trng_health_test
    import trng_pkg::*;
#(
    parameter int RCT_CUTOFF = 32,
    parameter int APT_WINDOW = 512,
    parameter int APT_CUTOFF = 410
) (
    input  logic clk,
    input  logic rst,
    input  logic sample,
    input  logic sample_strobe,
    input  logic restart,
    output logic rct_trip,
    output logic apt_trip
);

    localparam int RW = cnt_w(RCT_CUTOFF);
    localparam int AW = cnt_w(APT_WINDOW);

    logic          first_q;
    logic          prev_q;
    logic [RW-1:0] run_q, run_nx;
    logic          ref_q, ref_nx;
    logic [AW-1:0] win_q;
    logic [AW-1:0] apt_q, apt_nx;

    // Trips are evaluated on the incoming sample so the top can react on the same edge.
    always_comb begin
        run_nx   = (first_q || (sample != prev_q)) ? RW'(1) : run_q + 1'b1;
        ref_nx   = (win_q == '0) ? sample : ref_q;
        apt_nx   = (win_q == '0) ? AW'(1) : apt_q + AW'(sample == ref_q);
        rct_trip = sample_strobe && (run_nx >= RW'(RCT_CUTOFF));
        apt_trip = sample_strobe && (apt_nx >= AW'(APT_CUTOFF));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_q <= 1'b1;
            prev_q  <= 1'b0;
            run_q   <= '0;
            ref_q   <= 1'b0;
            win_q   <= '0;
            apt_q   <= '0;
        end else if (restart) begin
            first_q <= 1'b1;
            prev_q  <= 1'b0;
            run_q   <= '0;
            ref_q   <= 1'b0;
            win_q   <= '0;
            apt_q   <= '0;
        end else if (sample_strobe) begin
            first_q <= 1'b0;
            prev_q  <= sample;
            run_q   <= run_nx;
            ref_q   <= ref_nx;
            apt_q   <= apt_nx;
            win_q   <= (win_q == AW'(APT_WINDOW - 1)) ? '0 : win_q + 1'b1;
        end
    end

endmodule

// File: rtl/trng_bit_collector.sv
// Decimates the raw ring-generator bit, runs health tests, and packs accepted bits into words.
module trng_bit_collector
    import trng_pkg::*;
#(
    parameter int WORD_W      = 32,
    parameter int DECIM       = 4,
    parameter int WARMUP_BITS = 256,
    parameter int RCT_CUTOFF  = 32,
    parameter int APT_WINDOW  = 512,
    parameter int APT_CUTOFF  = 410
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clear_fail,
    input  logic              bit_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              health_fail,
    output logic [1:0]        fail_cause,
    output logic [15:0]       drop_cnt
);

    localparam int DW = cnt_w(DECIM);
    localparam int BW = cnt_w(WORD_W);
    localparam int WW = cnt_w(WARMUP_BITS);

    state_t            state, state_nx;
    logic [DW-1:0]     decim_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [WW-1:0]     warm_cnt;
    logic [WORD_W-1:0] shreg;
    logic              active, strobe, trip, take, restart, word_done;
    logic              rct_trip, apt_trip;

    trng_health_test #(
        .RCT_CUTOFF(RCT_CUTOFF),
        .APT_WINDOW(APT_WINDOW),
        .APT_CUTOFF(APT_CUTOFF)
    ) u_health (
        .clk          (clk),
        .rst          (rst),
        .sample       (bit_in),
        .sample_strobe(strobe),
        .restart      (restart),
        .rct_trip     (rct_trip),
        .apt_trip     (apt_trip)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (en) state_nx = ST_WARMUP;
            ST_WARMUP, ST_COLLECT: begin
                if (trip)     state_nx = ST_FAIL;
                else if (!en) state_nx = ST_IDLE;
                else if (state == ST_WARMUP && take && warm_cnt == WW'(WARMUP_BITS - 1))
                    state_nx = ST_COLLECT;
            end
            ST_FAIL:   if (clear_fail) state_nx = ST_WARMUP;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // A strobe that trips, or lands while en is low, never reaches the packer.
    always_comb begin
        active    = (state == ST_WARMUP) || (state == ST_COLLECT);
        strobe    = active && (decim_cnt == DW'(DECIM - 1));
        trip      = strobe && (rct_trip || apt_trip);
        take      = strobe && en && !trip;
        restart   = !active;
        word_done = take && (state == ST_COLLECT) && (bit_cnt == BW'(WORD_W - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            decim_cnt <= '0;
            bit_cnt   <= '0;
            warm_cnt  <= '0;
            shreg     <= '0;
        end else if (!active) begin
            decim_cnt <= '0;
            bit_cnt   <= '0;
            warm_cnt  <= '0;
        end else begin
            decim_cnt <= strobe ? '0 : decim_cnt + 1'b1;
            if (take) begin
                if (state == ST_WARMUP) begin
                    warm_cnt <= warm_cnt + 1'b1;
                end else begin
                    shreg   <= {shreg[WORD_W-2:0], bit_in};
                    bit_cnt <= (bit_cnt == BW'(WORD_W - 1)) ? '0 : bit_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            drop_cnt    <= '0;
            health_fail <= 1'b0;
            fail_cause  <= CAUSE_NONE;
        end else begin
            if (trip) begin
                out_valid <= 1'b0;
            end else if (word_done && (!out_valid || out_ready)) begin
                out_valid <= 1'b1;
                out_data  <= {shreg[WORD_W-2:0], bit_in};
            end else begin
                if (out_valid && out_ready) out_valid <= 1'b0;
                if (word_done && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
            end

            if (trip) begin
                health_fail <= 1'b1;
                fail_cause  <= (rct_trip && apt_trip) ? CAUSE_BOTH :
                               rct_trip               ? CAUSE_RCT  : CAUSE_APT;
            end else if (state == ST_FAIL && clear_fail) begin
                health_fail <= 1'b0;
                fail_cause  <= CAUSE_NONE;
            end
        end
    end

endmodule
